// File: rtl/data_fast_enable.sv
// Paces bursty single-cycle fast_enable requests into slow_enable pulses spaced
// at least DIV clocks apart, queuing the excess in a saturating pending counter.
module data_fast_enable #(
    parameter int DIV   = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fast_enable,
    input  logic             clear_overflow,
    output logic             slow_enable,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    localparam int               TMR_W      = $clog2(DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(DIV - 1);

    logic             slow_q, slow_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             overflow_q, overflow_d;
    logic             go;
    logic             drop;

    always_comb begin
        slow_d     = 1'b0;
        pending_d  = pending_q;
        timer_d    = timer_q;
        overflow_d = overflow_q;
        drop       = 1'b0;
        go         = (timer_q == '0) && ((pending_q != '0) || fast_enable);

        if (go) begin
            slow_d  = 1'b1;
            timer_d = TMR_RELOAD;
            // A request arriving on a drain cycle replaces the one issued.
            if (!fast_enable) begin
                pending_d = pending_q - CNT_W'(1);
            end
        end else begin
            if (timer_q != '0) begin
                timer_d = timer_q - TMR_W'(1);
            end
            if (fast_enable) begin
                if (pending_q == CNT_MAX) begin
                    drop = 1'b1;
                end else begin
                    pending_d = pending_q + CNT_W'(1);
                end
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slow_q     <= 1'b0;
            pending_q  <= '0;
            timer_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            slow_q     <= slow_d;
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            overflow_q <= overflow_d;
        end
    end

    assign slow_enable = slow_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;
    assign busy        = (pending_q != '0) || (timer_q != '0);

endmodule

// File: tb/tb_data_fast_enable.sv
// Bench for data_fast_enable: three instances (DIV/CNT_W = 8/4, 8/2, 1/4) share
// one stimulus stream; a pulse-time scoreboard plus spot vectors check outputs.
module tb_data_fast_enable;

    localparam int NDUT  = 3;
    localparam int QSIZE = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       fast_enable;
    logic       clear_overflow;
    logic [2:0] slow;
    logic [2:0] busy;
    logic [2:0] ovf;
    logic [3:0] pend_a;
    logic [1:0] pend_b;
    logic [3:0] pend_c;

    always #5 clk = ~clk;

    data_fast_enable #(.DIV(8), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .fast_enable(fast_enable), .clear_overflow(clear_overflow),
        .slow_enable(slow[0]), .pending(pend_a), .busy(busy[0]), .overflow(ovf[0]));

    data_fast_enable #(.DIV(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .fast_enable(fast_enable), .clear_overflow(clear_overflow),
        .slow_enable(slow[1]), .pending(pend_b), .busy(busy[1]), .overflow(ovf[1]));

    data_fast_enable #(.DIV(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .fast_enable(fast_enable), .clear_overflow(clear_overflow),
        .slow_enable(slow[2]), .pending(pend_c), .busy(busy[2]), .overflow(ovf[2]));

    typedef struct {
        string       name;
        int          sel;
        int          ncyc;
        int          exp_pulses;
        logic [63:0] rst_m;
        logic [63:0] fast_m;
        logic [63:0] clr_m;
    } scen_t;

    typedef struct {
        int   scen;
        int   cyc;
        logic slow;
        int   pend;
        logic busy;
        logic ovf;
    } spot_t;

    scen_t scens[9];
    spot_t spots[$];

    int checks = 0;
    int errors = 0;
    int g      = 0;
    int pulses;

    // Scoreboard: expected slow_enable times per instance, in issue order.
    int   q_t [NDUT][QSIZE];
    int   q_head [NDUT];
    int   q_tail [NDUT];
    int   last_pulse [NDUT];
    logic ovf_m [NDUT];

    function automatic int div_of(input int k);
        return (k == 2) ? 1 : 8;
    endfunction

    function automatic int max_of(input int k);
        return (k == 1) ? 3 : 15;
    endfunction

    function automatic int pend_of(input int k);
        if (k == 0) return int'(pend_a);
        if (k == 1) return int'(pend_b);
        return int'(pend_c);
    endfunction

    function automatic scen_t mk(input string n, input int sel, input int ncyc, input int ep,
                                 input logic [63:0] r, input logic [63:0] f, input logic [63:0] cl);
        scen_t s;
        s.name = n; s.sel = sel; s.ncyc = ncyc; s.exp_pulses = ep;
        s.rst_m = r; s.fast_m = f; s.clr_m = cl;
        return s;
    endfunction

    task automatic chk(input string what, input int k, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d (t=%0d): got %0d expected %0d", what, k, c, g, act, exp);
        end
    endtask

    task automatic check_cycle(input int s, input int c);
        logic exp_s;
        int   exp_p;
        logic exp_b;
        int   k;
        for (int d = 0; d < NDUT; d++) begin
            exp_s = (q_tail[d] > q_head[d]) && (q_t[d][q_head[d]] == g);
            if (exp_s) begin
                q_head[d]++;
                last_pulse[d] = g;
            end
            exp_p = q_tail[d] - q_head[d];
            exp_b = (exp_p != 0) || (g < last_pulse[d] + div_of(d) - 1);
            if (g > 0) begin
                chk("slow_enable", d, c, int'(slow[d]), int'(exp_s));
                chk("pending",     d, c, pend_of(d),    exp_p);
                chk("busy",        d, c, int'(busy[d]), int'(exp_b));
                chk("overflow",    d, c, int'(ovf[d]),  int'(ovf_m[d]));
            end
            if (d == scens[s].sel && slow[d] === 1'b1) pulses++;
        end
        k = scens[s].sel;
        foreach (spots[i]) begin
            if (spots[i].scen == s && spots[i].cyc == c) begin
                chk("spot_slow",     k, c, int'(slow[k]), int'(spots[i].slow));
                chk("spot_pending",  k, c, pend_of(k),    spots[i].pend);
                chk("spot_busy",     k, c, int'(busy[k]), int'(spots[i].busy));
                chk("spot_overflow", k, c, int'(ovf[k]),  int'(spots[i].ovf));
            end
        end
    endtask

    task automatic model_inputs(input logic r, input logic f, input logic cl);
        int   n;
        int   last;
        int   t;
        logic drop;
        for (int d = 0; d < NDUT; d++) begin
            if (r) begin
                q_head[d]     = 0;
                q_tail[d]     = 0;
                last_pulse[d] = -1000;
                ovf_m[d]      = 1'b0;
            end else begin
                drop = 1'b0;
                if (f) begin
                    // Accepted iff fewer than max requests would still wait after this edge.
                    n = q_tail[d] - q_head[d];
                    if (n > 0 && q_t[d][q_head[d]] == g + 1) n--;
                    if (n < max_of(d) && q_tail[d] < QSIZE) begin
                        last = (q_tail[d] > q_head[d]) ? q_t[d][q_tail[d]-1] : last_pulse[d];
                        t    = (g + 1 > last + div_of(d)) ? g + 1 : last + div_of(d);
                        q_t[d][q_tail[d]] = t;
                        q_tail[d]++;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (drop)    ovf_m[d] = 1'b1;
                else if (cl) ovf_m[d] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [63:0] rf;
        logic [63:0] rc;
        for (int d = 0; d < NDUT; d++) begin
            q_head[d] = 0; q_tail[d] = 0; last_pulse[d] = -1000; ovf_m[d] = 1'b0;
        end

        rf = '0;
        rc = '0;
        for (int b = 2; b <= 40; b++) begin
            rf[b] = ($urandom_range(0, 3) == 0);
            rc[b] = ($urandom_range(0, 15) == 0);
        end

        scens[0] = mk("reset",    0, 30,  0, 64'h3,          64'h3,          64'h0);
        scens[1] = mk("single",   0, 30,  1, 64'h1,          64'h400,        64'h0);
        scens[2] = mk("burst",    0, 40,  3, 64'h1,          64'h1C00,       64'h0);
        scens[3] = mk("simul",    0, 40,  3, 64'h1,          64'h40C00,      64'h0);
        scens[4] = mk("rst_mid",  0, 45,  1, 64'h4001,       64'h1C00,       64'h0);
        scens[5] = mk("ovf_cnt2", 1, 50,  4, 64'h1,          64'hFC00,       64'h100_0000_0000);
        scens[6] = mk("div1",     2, 30,  5, 64'h1,          64'h7C00,       64'h0);
        scens[7] = mk("set_wins", 1, 45,  4, 64'h1,          64'hFC00,       64'h10C000);
        scens[8] = mk("random",   0, 64, -1, 64'h1,          rf,             rc);

        //           scen cyc slow pend busy ovf
        spots.push_back('{0,  1, 1'b0, 0, 1'b0, 1'b0});
        spots.push_back('{0,  2, 1'b0, 0, 1'b0, 1'b0});
        spots.push_back('{1, 11, 1'b1, 0, 1'b1, 1'b0});
        spots.push_back('{1, 17, 1'b0, 0, 1'b1, 1'b0});
        spots.push_back('{1, 18, 1'b0, 0, 1'b0, 1'b0});
        spots.push_back('{2, 11, 1'b1, 0, 1'b1, 1'b0});
        spots.push_back('{2, 13, 1'b0, 2, 1'b1, 1'b0});
        spots.push_back('{2, 19, 1'b1, 1, 1'b1, 1'b0});
        spots.push_back('{2, 20, 1'b0, 1, 1'b1, 1'b0});
        spots.push_back('{2, 27, 1'b1, 0, 1'b1, 1'b0});
        spots.push_back('{2, 28, 1'b0, 0, 1'b1, 1'b0});
        spots.push_back('{3, 19, 1'b1, 1, 1'b1, 1'b0});
        spots.push_back('{3, 27, 1'b1, 0, 1'b1, 1'b0});
        spots.push_back('{4, 14, 1'b0, 2, 1'b1, 1'b0});
        spots.push_back('{4, 15, 1'b0, 0, 1'b0, 1'b0});
        spots.push_back('{5, 14, 1'b0, 3, 1'b1, 1'b0});
        spots.push_back('{5, 15, 1'b0, 3, 1'b1, 1'b1});
        spots.push_back('{5, 35, 1'b1, 0, 1'b1, 1'b1});
        spots.push_back('{5, 41, 1'b0, 0, 1'b1, 1'b0});
        spots.push_back('{6, 11, 1'b1, 0, 1'b0, 1'b0});
        spots.push_back('{6, 15, 1'b1, 0, 1'b0, 1'b0});
        spots.push_back('{6, 16, 1'b0, 0, 1'b0, 1'b0});
        spots.push_back('{7, 16, 1'b0, 3, 1'b1, 1'b1});
        spots.push_back('{7, 21, 1'b0, 2, 1'b1, 1'b0});

        for (int s = 0; s < 9; s++) begin
            pulses = 0;
            for (int c = 0; c < scens[s].ncyc; c++) begin
                check_cycle(s, c);
                rst            = scens[s].rst_m[c];
                fast_enable    = scens[s].fast_m[c];
                clear_overflow = scens[s].clr_m[c];
                model_inputs(rst, fast_enable, clear_overflow);
                @(posedge clk);
                #1;
                g++;
            end
            if (scens[s].exp_pulses >= 0) begin
                chk("pulse_count", scens[s].sel, scens[s].ncyc, pulses, scens[s].exp_pulses);
            end
            $display("scenario %-8s dut%0d cycles %0d pulses %0d", scens[s].name, scens[s].sel,
                     scens[s].ncyc, pulses);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
